// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg: shared constants and types for the physical-memory arbiter
package pmem_arb_pkg;
  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = $clog2(LINE_W / 8);
  localparam int CNT_W       = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;
endpackage

// File: rtl/line_burst_buffer.sv
// line_burst_buffer: one cache line of storage plus the beat counter that walks it
module line_burst_buffer
  import pmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_line,
  input  logic              capture_beat,
  input  logic              advance,
  input  logic              clr,
  input  logic [LINE_W-1:0] line_in,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [LINE_W-1:0] line_out,
  output logic [BEAT_W-1:0] beat_out,
  output logic              last_beat
);
  logic [LINE_W-1:0] line_q;
  logic [CNT_W-1:0]  k_q;
  // whole-line load for write-backs, per-beat capture for reads; counter steps on every accepted beat
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      line_q <= '0;
      k_q    <= '0;
    end else begin
      if (load_line) line_q <= line_in;
      else if (capture_beat) line_q[BEAT_W*k_q +: BEAT_W] <= beat_in;
      if (clr) k_q <= '0;
      else if (capture_beat | advance) k_q <= k_q + 1'b1;
    end
  assign line_out  = line_q;
  assign beat_out  = line_q[BEAT_W*k_q +: BEAT_W];
  assign last_beat = k_q == CNT_W'(BEATS - 1);
endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: grants I/D cache line requests one at a time and bursts them over the 64-bit memory port (ARB_ROUND_ROBIN_EN selects round-robin tie-breaking)
module pmem_arbiter
  import pmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  arb_state_t        state_q;
  req_id_t           id_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic              mem_read_q, mem_write_q, i_resp_q, d_resp_q;
  logic              d_req, tie_d, pick_d, grant, load_line, capture, advance, clr, last_beat;
  logic [LINE_W-1:0] line;
  logic [BEAT_W-1:0] beat;
`ifdef ARB_ROUND_ROBIN_EN
  req_id_t           last_q;
  // on a tie the requester not granted last wins
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= REQ_I;
    else if (grant) last_q <= pick_d ? REQ_D : REQ_I;
  assign tie_d = last_q == REQ_I;
`else
  assign tie_d = 1'b1;
`endif
  assign d_req     = d_read | d_write;
  assign pick_d    = d_req & (~i_read | tie_d);
  assign grant     = state_q == IDLE && (d_req | i_read);
  assign load_line = grant & pick_d & d_write;
  assign capture   = state_q == RD_BURST && mem_resp;
  assign advance   = state_q == WR_BURST && mem_resp;
  assign clr       = state_q == DONE;
  line_burst_buffer u_buf (
    .clk          (clk),
    .rst          (rst),
    .load_line    (load_line),
    .capture_beat (capture),
    .advance      (advance),
    .clr          (clr),
    .line_in      (d_wdata),
    .beat_in      (mem_rdata),
    .line_out     (line),
    .beat_out     (beat),
    .last_beat    (last_beat)
  );
  // arbitration FSM; requests are only looked at in IDLE so the grant is stable for a whole burst
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q       <= IDLE;
      id_q          <= REQ_I;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      i_resp_q      <= 1'b0;
      d_resp_q      <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      case (state_q)
        IDLE: if (grant) begin
          id_q          <= pick_d ? REQ_D : REQ_I;
          mem_address_q <= (pick_d ? d_address : i_address) & ({ADDR_W{1'b1}} << OFFSET_BITS);
          mem_write_q   <= load_line;
          mem_read_q    <= ~load_line;
          state_q       <= load_line ? WR_BURST : RD_BURST;
        end
        RD_BURST, WR_BURST: if (mem_resp && last_beat) begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          i_resp_q    <= id_q == REQ_I;
          d_resp_q    <= id_q == REQ_D;
          state_q     <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wdata   = mem_write_q ? beat : '0;
  assign i_resp      = i_resp_q;
  assign d_resp      = d_resp_q;
  assign i_rdata     = line;
  assign d_rdata     = line;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed self-checking bench for pmem_arbiter
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;
  logic              clk = 1'b0, rst = 1'b1;
  logic [ADDR_W-1:0] i_address = '0, d_address = '0, mem_address;
  logic              i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, mem_resp = 1'b0;
  logic [LINE_W-1:0] d_wdata = '0, i_rdata, d_rdata;
  logic              i_resp, d_resp, mem_read, mem_write;
  logic [BEAT_W-1:0] mem_wdata, mem_rdata = '0;
  int vecs = 0, errs = 0;
  localparam logic [LINE_W-1:0] L1 = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
  localparam logic [LINE_W-1:0] L2 = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
  localparam logic [LINE_W-1:0] L3 = {64'h3333_0003, 64'h3333_0002, 64'h3333_0001, 64'h3333_0000};
  localparam logic [LINE_W-1:0] L4 = {64'hFEED_4444, 64'hCAFE_4444, 64'hBEEF_4444, 64'hDEAD_4444};

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chkl(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    chkl(tag, LINE_W'(obs), LINE_W'(exp));
  endtask
  task automatic chka(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
    chkl(tag, LINE_W'(obs), LINE_W'(exp));
  endtask
  task automatic chkw(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
    chkl(tag, LINE_W'(obs), LINE_W'(exp));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // memory side of one burst: gap idle cycles before each beat, then a mem_resp pulse
  task automatic burst(input bit wr, input logic [LINE_W-1:0] line, input int gap);
    for (int k = 0; k < BEATS; k++) begin
      repeat (gap) step();
      if (wr) chkw("wdata_beat", mem_wdata, line[BEAT_W*k +: BEAT_W]);
      chk1(wr ? "mem_write_held" : "mem_read_held", wr ? mem_write : mem_read, 1'b1);
      mem_rdata = wr ? '0 : line[BEAT_W*k +: BEAT_W];
      mem_resp  = 1'b1;
      step();
      mem_resp  = 1'b0;
      mem_rdata = '0;
      if (k < BEATS - 1) chk1("no_early_resp", i_resp | d_resp, 1'b0);
    end
  endtask

  initial begin
    step();
    step();
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chka("rst_mem_address", mem_address, '0);
    chk1("rst_resp", i_resp | d_resp, 1'b0);
    chkl("rst_i_rdata", i_rdata, '0);
    chkw("rst_mem_wdata", mem_wdata, '0);
    rst = 1'b0;
    // stray mem_resp in IDLE must be ignored
    mem_resp = 1'b1; mem_rdata = 64'hFF;
    step();
    mem_resp = 1'b0; mem_rdata = '0;
    // 1: icache read
    i_read = 1'b1; i_address = 32'h0000_1234;
    chk1("t1_no_read_before_edge", mem_read, 1'b0);
    step();
    chk1("t1_mem_read", mem_read, 1'b1);
    chk1("t1_mem_write", mem_write, 1'b0);
    chka("t1_mem_address", mem_address, 32'h0000_1220);
    burst(1'b0, L1, 0);
    chk1("t1_i_resp", i_resp, 1'b1);
    chk1("t1_d_resp", d_resp, 1'b0);
    chkl("t1_i_rdata", i_rdata, L1);
    chk1("t1_read_dropped", mem_read, 1'b0);
    i_read = 1'b0;
    step();
    chk1("t1_resp_pulse", i_resp, 1'b0);
    // 2: dcache write-back then refill read requested in DONE
    d_write = 1'b1; d_address = 32'h40; d_wdata = L2;
    step();
    chk1("t2_mem_write", mem_write, 1'b1);
    chk1("t2_mem_read", mem_read, 1'b0);
    chka("t2_mem_address", mem_address, 32'h40);
    burst(1'b1, L2, 0);
    chk1("t2_d_resp", d_resp, 1'b1);
    chk1("t2_i_resp", i_resp, 1'b0);
    chk1("t2_write_dropped", mem_write, 1'b0);
    d_write = 1'b0; d_read = 1'b1; d_address = 32'h80;
    step();
    chk1("t2_idle_after_done", mem_read | mem_write, 1'b0);
    chk1("t2_resp_pulse", d_resp, 1'b0);
    step();
    chk1("t2_refill_read", mem_read, 1'b1);
    chka("t2_refill_address", mem_address, 32'h80);
    burst(1'b0, L3, 0);
    chk1("t2_refill_resp", d_resp, 1'b1);
    chkl("t2_d_rdata", d_rdata, L3);
    d_read = 1'b0;
    step();
    // 3: simultaneous requests, from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_read = 1'b1; i_address = 32'h1000; d_read = 1'b1; d_address = 32'h2000;
    step();
    chka("t3_first_is_d", mem_address, 32'h2000);
    burst(1'b0, L4, 0);
    chk1("t3_d_resp", d_resp, 1'b1);
    chk1("t3_i_waits", i_resp, 1'b0);
    d_read = 1'b0;
    step();
    step();
    chka("t3_second_is_i", mem_address, 32'h1000);
    chk1("t3_second_read", mem_read, 1'b1);
    burst(1'b0, L1, 0);
    chk1("t3_i_resp", i_resp, 1'b1);
    chkl("t3_i_rdata", i_rdata, L1);
    d_read = 1'b1;
    step();
    step();
    chka("t3_tie_after_i", mem_address, 32'h2000);
    burst(1'b0, L2, 0);
    chk1("t3_tie_after_i_resp", d_resp, 1'b1);
    step();
    step();
`ifdef ARB_ROUND_ROBIN_EN
    chka("t3_tie_after_d", mem_address, 32'h1000);
    burst(1'b0, L3, 0);
    chk1("t3_tie_after_d_resp", i_resp, 1'b1);
`else
    chka("t3_tie_after_d", mem_address, 32'h2000);
    burst(1'b0, L3, 0);
    chk1("t3_tie_after_d_resp", d_resp, 1'b1);
`endif
    i_read = 1'b0; d_read = 1'b0;
    step();
    // 4: gapped beats
    i_read = 1'b1; i_address = 32'h3010;
    step();
    chka("t4_mem_address", mem_address, 32'h3000);
    burst(1'b0, L3, 1);
    chk1("t4_i_resp", i_resp, 1'b1);
    chkl("t4_i_rdata", i_rdata, L3);
    i_read = 1'b0;
    step();
    // 5: reset after beat 2, then re-issue
    i_read = 1'b1; i_address = 32'h4000;
    step();
    for (int k = 0; k < 2; k++) begin
      mem_resp = 1'b1; mem_rdata = 64'h5500 + 64'(k);
      step();
      mem_resp = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk1("t5_read_drops", mem_read, 1'b0);
    chka("t5_addr_cleared", mem_address, '0);
    chkl("t5_rdata_cleared", i_rdata, '0);
    step();
    chk1("t5_no_resp", i_resp | d_resp, 1'b0);
    rst = 1'b0;
    step();
    chk1("t5_reissue_read", mem_read, 1'b1);
    chka("t5_reissue_address", mem_address, 32'h4000);
    burst(1'b0, L4, 0);
    chk1("t5_i_resp", i_resp, 1'b1);
    chkl("t5_i_rdata", i_rdata, L4);
    i_read = 1'b0;
    step();
    // 6: icache request arriving during a dcache burst
    d_read = 1'b1; d_address = 32'h300;
    step();
    chka("t6_d_address", mem_address, 32'h300);
    i_read = 1'b1; i_address = 32'h500;
    burst(1'b0, L1, 0);
    chka("t6_no_addr_change", mem_address, 32'h300);
    chk1("t6_d_resp", d_resp, 1'b1);
    chk1("t6_i_waits", i_resp, 1'b0);
    d_read = 1'b0;
    step();
    chk1("t6_no_grant_in_done", mem_read, 1'b0);
    step();
    chk1("t6_i_granted", mem_read, 1'b1);
    chka("t6_i_address", mem_address, 32'h500);
    burst(1'b0, L2, 0);
    chk1("t6_i_resp", i_resp, 1'b1);
    chkl("t6_i_rdata", i_rdata, L2);
    i_read = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
